// File: rtl/cordic_sincos_param_if.sv
// Start/busy/done handshake and angle/result bus of the sin/cos CORDIC core.
interface cordic_sincos_param_if #(
   parameter int WL = 21
) ();
   logic                 start;
   logic signed [WL-1:0] angle_in;
   logic                 busy;
   logic                 done;
   logic signed [WL-1:0] cos_out;
   logic signed [WL-1:0] sin_out;

   modport master (
      output start, angle_in,
      input  busy, done, cos_out, sin_out
   );

   modport slave (
      input  start, angle_in,
      output busy, done, cos_out, sin_out
   );
endinterface

// File: rtl/cordic_sincos_param.sv
// Rotation-mode CORDIC returning cos and sin of a Q3.(WL-3) angle in [-pi, pi],
// UNROLL chained micro-rotations per enabled clock, results held until next done.
//
// state | meaning
// IDLE  | waiting for start; result registers hold last cos/sin
// RUN   | UNROLL micro-rotations per enabled cycle until ITER are done
module cordic_sincos_param #(
   parameter int WL     = 21,
   parameter int ITER   = 16,
   parameter int UNROLL = 4
) (
   input  logic                  clock,
   input  logic                  aclr_n,
   input  logic                  clk_en,
   cordic_sincos_param_if.slave  bus
);

   localparam int IW   = $clog2(ITER);
   localparam int SH_Z = 35 - WL;
   localparam int SH_X = 34 - WL;

   localparam logic [63:0] ATAN32 [24] = '{
      64'd3373259426, 64'd1991351318, 64'd1052175346, 64'd534100635,
      64'd268086748,  64'd134174063,  64'd67103403,   64'd33553749,
      64'd16777131,   64'd8388597,    64'd4194303,    64'd2097152,
      64'd1048576,    64'd524288,     64'd262144,     64'd131072,
      64'd65536,      64'd32768,      64'd16384,      64'd8192,
      64'd4096,       64'd2048,       64'd1024,       64'd512
   };
   localparam logic [63:0] K32     = 64'd2608131496;
   localparam logic [63:0] PI32    = 64'd13493037704;
   localparam logic [63:0] K_R     = (K32 + (64'd1 << (SH_X - 1))) >> SH_X;
   localparam logic [63:0] PI_R    = (PI32 + (64'd1 << (SH_Z - 1))) >> SH_Z;
   localparam logic [63:0] PI2_R   = ((PI32 >> 1) + (64'd1 << (SH_Z - 1))) >> SH_Z;
   localparam logic signed [WL-1:0] K_Q   = K_R[WL-1:0];
   localparam logic signed [WL-1:0] PI_Q  = PI_R[WL-1:0];
   localparam logic signed [WL-1:0] PI2_Q = PI2_R[WL-1:0];

   if (WL < 16 || WL > 32) begin : g_bad_wl
      $error("cordic_sincos_param: WL must be 16..32");
   end
   if (ITER < 8 || ITER > 24) begin : g_bad_iter
      $error("cordic_sincos_param: ITER must be 8..24");
   end
   if (UNROLL < 1 || (ITER % UNROLL) != 0) begin : g_bad_unroll
      $error("cordic_sincos_param: UNROLL must divide ITER");
   end

   logic signed [WL-1:0] atan_tab [ITER];
   for (genvar g = 0; g < ITER; g++) begin : g_atan
      localparam logic [63:0] A_R = (ATAN32[g] + (64'd1 << (SH_Z - 1))) >> SH_Z;
      assign atan_tab[g] = A_R[WL-1:0];
   end

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state;
   logic [IW-1:0]        idx;
   logic signed [WL-1:0] x_r, y_r, z_r;
   logic                 fold;
   logic                 busy_r, done_r;
   logic signed [WL-1:0] cos_r, sin_r;

   logic signed [WL-1:0] xc [UNROLL+1];
   logic signed [WL-1:0] yc [UNROLL+1];
   logic signed [WL-1:0] zc [UNROLL+1];
   logic [IW-1:0]        sel;
   logic                 last;

   always_comb begin
      xc[0] = x_r;
      yc[0] = y_r;
      zc[0] = z_r;
      sel   = '0;
      for (int k = 0; k < UNROLL; k++) begin
         sel = idx + IW'(k);
         if (!zc[k][WL-1]) begin
            xc[k+1] = xc[k] - (yc[k] >>> sel);
            yc[k+1] = yc[k] + (xc[k] >>> sel);
            zc[k+1] = zc[k] - atan_tab[sel];
         end else begin
            xc[k+1] = xc[k] + (yc[k] >>> sel);
            yc[k+1] = yc[k] - (xc[k] >>> sel);
            zc[k+1] = zc[k] + atan_tab[sel];
         end
      end
   end

   assign last = (int'(idx) + UNROLL) == ITER;

   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         state  <= IDLE;
         idx    <= '0;
         x_r    <= '0;
         y_r    <= '0;
         z_r    <= '0;
         fold   <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         cos_r  <= '0;
         sin_r  <= '0;
      end else if (clk_en) begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  // Fold outer quadrants onto [-pi/2, pi/2]; result is negated at the end.
                  if (bus.angle_in > PI2_Q) begin
                     z_r  <= bus.angle_in - PI_Q;
                     fold <= 1'b1;
                  end else if (bus.angle_in < -PI2_Q) begin
                     z_r  <= bus.angle_in + PI_Q;
                     fold <= 1'b1;
                  end else begin
                     z_r  <= bus.angle_in;
                     fold <= 1'b0;
                  end
                  x_r    <= K_Q;
                  y_r    <= '0;
                  idx    <= '0;
                  busy_r <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               x_r <= xc[UNROLL];
               y_r <= yc[UNROLL];
               z_r <= zc[UNROLL];
               idx <= idx + IW'(UNROLL);
               if (last) begin
                  cos_r  <= fold ? -xc[UNROLL] : xc[UNROLL];
                  sin_r  <= fold ? -yc[UNROLL] : yc[UNROLL];
                  done_r <= 1'b1;
                  busy_r <= 1'b0;
                  idx    <= '0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.cos_out = cos_r;
   assign bus.sin_out = sin_r;

endmodule

// File: tb/tb_cordic_sincos_param.sv
// Scoreboard bench for cordic_sincos_param: default core plus a WL=24/ITER=20 core,
// expected results from $cos/$sin of the input angle.
module tb_cordic_sincos_param;

   localparam int WL      = 21;
   localparam int ITER    = 16;
   localparam int UNROLL  = 4;
   localparam int LAT     = ITER / UNROLL;
   localparam int WL2     = 24;
   localparam int ITER2   = 20;
   localparam int UNROLL2 = 2;
   localparam int LAT2    = ITER2 / UNROLL2;
   localparam int TOL_D   = 24;
   localparam int TOL_R1  = 1 << ((WL - 2) - (ITER - 2));
   localparam int TOL_R2  = 1 << ((WL2 - 2) - (ITER2 - 2));

   logic clock   = 1'b0;
   logic aclr_n  = 1'b0;
   logic clk_en  = 1'b1;
   logic clk_en2 = 1'b1;

   cordic_sincos_param_if #(.WL(WL))  bus ();
   cordic_sincos_param_if #(.WL(WL2)) bus2 ();

   cordic_sincos_param #(.WL(WL), .ITER(ITER), .UNROLL(UNROLL)) dut (
      .clock  (clock),
      .aclr_n (aclr_n),
      .clk_en (clk_en),
      .bus    (bus)
   );

   cordic_sincos_param #(.WL(WL2), .ITER(ITER2), .UNROLL(UNROLL2)) dut2 (
      .clock  (clock),
      .aclr_n (aclr_n),
      .clk_en (clk_en2),
      .bus    (bus2)
   );

   always #5 clock = ~clock;

   typedef struct {
      real c;
      real s;
      int  cyc;
      int  tol;
   } exp_t;

   exp_t sb1[$];
   exp_t sb2[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;
   logic en_q  = 1'b0;
   real  pi_r  = 3.14159265358979;

   always @(posedge clock) begin
      cyc  <= cyc + 1;
      en_q <= clk_en;
   end

   function automatic void check(string nm, longint act, longint exp, longint tol);
      n_cmp++;
      if (act > exp + tol || act < exp - tol) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (+/-%0d) at cycle %0d", nm, act, exp, tol, cyc);
      end
   endfunction

   // Monitors: one pop per fresh done pulse (a done held by clk_en=0 counts once).
   always @(negedge clock) begin
      exp_t e;
      if (aclr_n && bus.done && en_q) begin
         if (sb1.size() == 0) begin
            check("dut1_unexpected_done", 1, 0, 0);
         end else begin
            e = sb1.pop_front();
            check("dut1_cos", longint'(bus.cos_out), longint'(e.c), e.tol);
            check("dut1_sin", longint'(bus.sin_out), longint'(e.s), e.tol);
            check("dut1_latency", cyc, e.cyc, 0);
         end
      end
   end

   always @(negedge clock) begin
      exp_t e;
      if (aclr_n && bus2.done) begin
         if (sb2.size() == 0) begin
            check("dut2_unexpected_done", 1, 0, 0);
         end else begin
            e = sb2.pop_front();
            check("dut2_cos", longint'(bus2.cos_out), longint'(e.c), e.tol);
            check("dut2_sin", longint'(bus2.sin_out), longint'(e.s), e.tol);
            check("dut2_latency", cyc, e.cyc, 0);
         end
      end
   end

   // Called at a negedge; start is sampled by the next rising edge.
   task automatic issue1(input int a, input int extra, input bit expect_it, input int tol);
      exp_t e;
      real  ar;
      bus.start    = 1'b1;
      bus.angle_in = WL'(a);
      if (expect_it) begin
         ar    = real'(a) / (2.0 ** (WL - 3));
         e.c   = $cos(ar) * (2.0 ** (WL - 2));
         e.s   = $sin(ar) * (2.0 ** (WL - 2));
         e.cyc = cyc + 1 + LAT + extra;
         e.tol = tol;
         sb1.push_back(e);
      end
      @(negedge clock);
      bus.start = 1'b0;
   endtask

   task automatic issue2(input int a);
      exp_t e;
      real  ar;
      bus2.start    = 1'b1;
      bus2.angle_in = WL2'(a);
      ar    = real'(a) / (2.0 ** (WL2 - 3));
      e.c   = $cos(ar) * (2.0 ** (WL2 - 2));
      e.s   = $sin(ar) * (2.0 ** (WL2 - 2));
      e.cyc = cyc + 1 + LAT2;
      e.tol = TOL_R2;
      sb2.push_back(e);
      @(negedge clock);
      bus2.start = 1'b0;
   endtask

   task automatic wait_idle1(input int max_cyc);
      int n = 0;
      while (bus.busy && n < max_cyc) begin
         @(negedge clock);
         n++;
      end
      if (bus.busy) check("dut1_busy_timeout", 1, 0, 0);
   endtask

   task automatic wait_idle2(input int max_cyc);
      int n = 0;
      while (bus2.busy && n < max_cyc) begin
         @(negedge clock);
         n++;
      end
      if (bus2.busy) check("dut2_busy_timeout", 1, 0, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int pmax1;
      int pmax2;
      int n;
      pmax1 = int'($floor(pi_r * (2.0 ** (WL - 3))));
      pmax2 = int'($floor(pi_r * (2.0 ** (WL2 - 3))));
      bus.start     = 1'b0;
      bus.angle_in  = '0;
      bus2.start    = 1'b0;
      bus2.angle_in = '0;
      aclr_n = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_busy", bus.busy, 0, 0);
      check("rst_done", bus.done, 0, 0);
      check("rst_cos", bus.cos_out, 0, 0);
      check("rst_sin", bus.sin_out, 0, 0);
      check("rst_busy2", bus2.busy, 0, 0);
      aclr_n = 1'b1;
      @(negedge clock);

      // angle 0: busy for exactly LAT cycles, single-cycle done
      issue1(0, 0, 1, TOL_D);
      for (int k = 0; k < LAT; k++) begin
         check("busy_during_run", bus.busy, 1, 0);
         @(negedge clock);
      end
      check("busy_after_run", bus.busy, 0, 0);
      check("done_pulse", bus.done, 1, 0);
      @(negedge clock);
      check("done_one_cycle", bus.done, 0, 0);

      issue1(274517, 0, 1, TOL_D);
      wait_idle1(LAT + 4);
      issue1(-655360, 0, 1, TOL_D);
      wait_idle1(LAT + 4);

      // start 2 cycles into a run is ignored; start on the done cycle is accepted
      issue1(300000, 0, 1, TOL_D);
      @(negedge clock);
      bus.start    = 1'b1;
      bus.angle_in = WL'(-500000);
      @(negedge clock);
      bus.start = 1'b0;
      wait_idle1(LAT + 4);
      check("done_at_rearm", bus.done, 1, 0);
      issue1(-100000, 0, 1, TOL_D);
      wait_idle1(LAT + 4);

      // clk_en low for 3 cycles mid-run delays done by exactly 3
      issue1(262144, 3, 1, TOL_D);
      clk_en = 1'b0;
      repeat (3) @(negedge clock);
      clk_en = 1'b1;
      wait_idle1(LAT + 4);
      clk_en = 1'b0;
      @(negedge clock);
      check("done_stretch", bus.done, 1, 0);
      clk_en = 1'b1;
      @(negedge clock);
      check("done_after_stretch", bus.done, 0, 0);

      // reset mid-run: outputs clear immediately and no done follows
      issue1(-262144, 0, 0, 0);
      @(negedge clock);
      aclr_n = 1'b0;
      #1;
      check("midrst_busy", bus.busy, 0, 0);
      check("midrst_done", bus.done, 0, 0);
      check("midrst_cos", bus.cos_out, 0, 0);
      check("midrst_sin", bus.sin_out, 0, 0);
      @(negedge clock);
      aclr_n = 1'b1;
      repeat (LAT + 4) @(negedge clock);
      issue1(411000, 0, 1, TOL_D);
      wait_idle1(LAT + 4);

      // back-to-back random angles on the default core
      repeat (1000) begin
         issue1(int'($urandom_range(2 * pmax1)) - pmax1, 0, 1, TOL_R1);
         wait_idle1(LAT + 4);
      end

      // second parameter set
      @(negedge clock);
      repeat (300) begin
         issue2(int'($urandom_range(2 * pmax2)) - pmax2);
         wait_idle2(LAT2 + 4);
      end

      n = 0;
      while ((sb1.size() + sb2.size()) != 0 && n < 50) begin
         @(negedge clock);
         n++;
      end
      check("scoreboard_drained", sb1.size() + sb2.size(), 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
